// File: rtl/hdmi_i2c_init_pkg.sv
`default_nettype none
//==============================================================================
// Module   : hdmi_i2c_init_pkg
// Brief    : Shared state encodings, entry layout and default register table
//            for the HDMI transmitter I2C init sequencer.
// Revision : 1.0 - initial release
//==============================================================================
package hdmi_i2c_init_pkg;

    localparam logic [3:0] c_st_startup   = 4'd0;
    localparam logic [3:0] c_st_fetch     = 4'd1;
    localparam logic [3:0] c_st_wr_reg    = 4'd2;
    localparam logic [3:0] c_st_wr_val    = 4'd3;
    localparam logic [3:0] c_st_wait_stop = 4'd4;
    localparam logic [3:0] c_st_gap       = 4'd5;
    localparam logic [3:0] c_st_delay     = 4'd6;
    localparam logic [3:0] c_st_done      = 4'd7;
    localparam logic [3:0] c_st_error     = 4'd8;

    // A register field of 8'hFF turns the entry into a delay of val milliseconds
    localparam logic [7:0] c_delay_marker = 8'hFF;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] val;
    } init_entry_t;

    // Room for 256 entries; entry 0 occupies the most significant 16 bits
    localparam int c_table_bits      = 4096;
    localparam int c_default_entries = 32;

    localparam logic [c_default_entries*16-1:0] c_default_list = {
        16'h4110, 16'hFF0A, 16'h9803, 16'h9AE0,
        16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4,
        16'hE0D0, 16'hF900, 16'h1500, 16'h1630,
        16'h1702, 16'h1846, 16'hAF06, 16'h4080,
        16'h4808, 16'h49A8, 16'h4C00, 16'h5500,
        16'h5608, 16'h9620, 16'hBA60, 16'hD03C,
        16'hD6C0, 16'hDE9C, 16'hE460, 16'hFA7D,
        16'h3B80, 16'h3C00, 16'h94C0, 16'h4110
    };

    localparam logic [c_table_bits-1:0] c_default_table =
        {c_default_list, {(c_table_bits - c_default_entries*16){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/hdmi_i2c_init_table.sv
`default_nettype none
//==============================================================================
// Module   : hdmi_i2c_init_table
// Brief    : Combinational ROM of {register, value} pairs for the HDMI
//            transmitter; index in, 16-bit entry out.
// Revision : 1.0 - initial release
//==============================================================================
module hdmi_i2c_init_table
    import hdmi_i2c_init_pkg::*;
#(
    parameter logic [c_table_bits-1:0] TABLE = c_default_table
) (
    input  logic [7:0]  i_index,
    output init_entry_t o_entry
);

    logic [11:0] w_lsb;

    assign w_lsb   = 12'(c_table_bits - 16) - {i_index, 4'b0000};
    assign o_entry = TABLE[w_lsb +: 16];

endmodule
`default_nettype wire

// File: rtl/hdmi_i2c_init_seq.sv
`default_nettype none
//==============================================================================
// Module   : hdmi_i2c_init_seq
// Brief    : Walks the init table and issues one 2-byte I2C write per entry,
//            with inline ms delays, per-byte timeout and bounded retry.
// Revision : 1.0 - initial release
//==============================================================================
module hdmi_i2c_init_seq
    import hdmi_i2c_init_pkg::*;
#(
    parameter int                      ADDRESSING       = 7,
    parameter logic [ADDRESSING-1:0]   DEVICE_ADDRESS   = 7'h39,
    parameter int                      SYSCLK_FREQ      = 100,
    parameter int                      NUM_ENTRIES      = 32,
    parameter int                      STARTUP_DELAY_MS = 10,
    parameter int                      BYTE_TIMEOUT_US  = 500,
    parameter int                      GAP_US           = 5,
    parameter int                      MAX_RETRY        = 3,
    parameter logic [c_table_bits-1:0] TABLE            = c_default_table
) (
    input  logic                  i_sysclk,
    input  logic                  i_arst,
    input  logic                  i_start,
    output logic                  o_m_en,
    output logic                  o_m_wr,
    output logic                  o_last,
    output logic [ADDRESSING-1:0] o_addr,
    output logic [7:0]            o_data,
    input  logic                  i_ack,
    input  logic                  i_last,
    input  logic [7:0]            i_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [7:0]            o_err_index,
    output logic [3:0]            o_dbg_state
);

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [8:0]  r_index;
    logic [3:0]  r_retry;
    logic [7:0]  r_reg;
    logic [7:0]  r_val;
    logic        r_m_en;
    logic        r_last;
    logic [7:0]  r_data;
    logic [7:0]  r_err_index;
    logic [15:0] r_us_cnt;
    logic [9:0]  r_ms_cnt;
    logic [15:0] r_elapsed;
    init_entry_t w_entry;
    logic        w_us_tick;
    logic        w_ms_tick;
    logic        w_unit_tick;
    logic        w_in_xfer;
    logic        w_pulse;
    logic        w_timeout;
    logic        w_can_retry;
    logic        w_byte_fail;
    logic        w_issue_reg;
    logic        w_unused;

    hdmi_i2c_init_table #(
        .TABLE (TABLE)
    ) u_table (
        .i_index (r_index[7:0]),
        .o_entry (w_entry)
    );

    assign w_us_tick   = (r_us_cnt == 16'(SYSCLK_FREQ - 1));
    assign w_ms_tick   = w_us_tick && (r_ms_cnt == 10'd999);
    // Startup and delay entries are timed in ms, everything else in us
    assign w_unit_tick = (r_state == c_st_startup || r_state == c_st_delay) ? w_ms_tick : w_us_tick;

    assign w_in_xfer   = (r_state == c_st_wr_reg) || (r_state == c_st_wr_val) || (r_state == c_st_wait_stop);
    assign w_pulse     = (r_state == c_st_wait_stop) ? i_last : i_ack;
    assign w_timeout   = (r_elapsed == 16'(BYTE_TIMEOUT_US));
    assign w_can_retry = (r_retry < 4'(MAX_RETRY));
    assign w_byte_fail = w_in_xfer && w_timeout && !w_pulse;
    assign w_issue_reg = (w_next == c_st_wr_reg) && (r_state != c_st_wr_reg);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_startup:   if (r_elapsed == 16'(STARTUP_DELAY_MS)) w_next = c_st_fetch;
            c_st_fetch: begin
                if (r_index == 9'(NUM_ENTRIES))                 w_next = c_st_done;
                else if (w_entry.reg_addr == c_delay_marker)    w_next = c_st_delay;
                else                                            w_next = c_st_wr_reg;
            end
            c_st_wr_reg, c_st_wr_val, c_st_wait_stop: begin
                if (w_pulse) begin
                    case (r_state)
                        c_st_wr_reg: w_next = c_st_wr_val;
                        c_st_wr_val: w_next = c_st_wait_stop;
                        default:     w_next = c_st_gap;
                    endcase
                end else if (w_timeout) begin
                    w_next = w_can_retry ? c_st_gap : c_st_error;
                end
            end
            // A non-zero retry count here means the gap precedes a re-attempt
            c_st_gap:       if (r_elapsed == 16'(GAP_US)) w_next = (r_retry != 4'd0) ? c_st_wr_reg : c_st_fetch;
            c_st_delay:     if (r_elapsed == {8'd0, r_val}) w_next = c_st_fetch;
            c_st_done:      w_next = c_st_done;
            c_st_error:     w_next = c_st_error;
            default:        w_next = c_st_startup;
        endcase
    end

    always_ff @(posedge i_sysclk) begin
        if (i_arst) begin
            r_state     <= c_st_startup;
            r_index     <= '0;
            r_retry     <= '0;
            r_reg       <= '0;
            r_val       <= '0;
            r_m_en      <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
            r_err_index <= '0;
            r_us_cnt    <= '0;
            r_ms_cnt    <= '0;
            r_elapsed   <= '0;
        end else if (i_start) begin
            r_state     <= c_st_startup;
            r_index     <= '0;
            r_retry     <= '0;
            r_m_en      <= 1'b0;
            r_last      <= 1'b0;
            r_err_index <= '0;
            r_us_cnt    <= '0;
            r_ms_cnt    <= '0;
            r_elapsed   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_us_cnt  <= '0;
                r_ms_cnt  <= '0;
                r_elapsed <= '0;
            end else begin
                r_us_cnt <= w_us_tick ? 16'd0 : r_us_cnt + 16'd1;
                if (w_us_tick)   r_ms_cnt  <= w_ms_tick ? 10'd0 : r_ms_cnt + 10'd1;
                if (w_unit_tick) r_elapsed <= r_elapsed + 16'd1;
            end

            if (r_state == c_st_fetch) begin
                r_reg <= w_entry.reg_addr;
                r_val <= w_entry.val;
            end
            if (w_issue_reg) begin
                r_m_en <= 1'b1;
                r_last <= 1'b0;
                r_data <= (r_state == c_st_fetch) ? w_entry.reg_addr : r_reg;
            end
            if (r_state == c_st_wr_reg && i_ack) begin
                r_data <= r_val;
                r_last <= 1'b1;
            end
            if (r_state == c_st_wr_val && i_ack) begin
                r_m_en <= 1'b0;
                r_last <= 1'b0;
            end
            if (r_state == c_st_wait_stop && i_last) begin
                r_index <= r_index + 9'd1;
                r_retry <= '0;
            end
            if (r_state == c_st_delay && w_next == c_st_fetch) begin
                r_index <= r_index + 9'd1;
            end
            if (w_byte_fail) begin
                r_m_en <= 1'b0;
                r_last <= 1'b0;
                if (w_can_retry) r_retry     <= r_retry + 4'd1;
                else             r_err_index <= r_index[7:0];
            end
        end
    end

    assign w_unused    = ^i_data;

    assign o_m_en      = r_m_en;
    assign o_m_wr      = 1'b1;
    assign o_last      = r_last;
    assign o_addr      = DEVICE_ADDRESS;
    assign o_data      = r_data;
    assign o_busy      = (r_state != c_st_done) && (r_state != c_st_error);
    assign o_done      = (r_state == c_st_done);
    assign o_error     = (r_state == c_st_error);
    assign o_err_index = r_err_index;
    assign o_dbg_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_i2c_init_seq.sv
`default_nettype none
//==============================================================================
// Module   : tb_hdmi_i2c_init_seq
// Brief    : Self-checking bench for hdmi_i2c_init_seq with a byte-level
//            I2C master model and table-driven ack/nack scenarios.
// Revision : 1.0 - initial release
//==============================================================================
module tb_hdmi_i2c_init_seq;
    import hdmi_i2c_init_pkg::*;

    // Entries: 10:55, 20:AA, delay 2 ms, 30:01, zero delay, 40:02
    localparam logic [c_table_bits-1:0] c_tb_table = {
        16'h1055, 16'h20AA, 16'hFF02, 16'h3001, 16'hFF00, 16'h4002,
        {(c_table_bits - 96){1'b0}}
    };

    logic       clk;
    logic       i_arst;
    logic       i_start;
    logic       o_m_en;
    logic       o_m_wr;
    logic       o_last;
    logic [6:0] o_addr;
    logic [7:0] o_data;
    logic       i_ack;
    logic       i_last;
    logic [7:0] i_data;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [7:0] o_err_index;
    logic [3:0] o_dbg_state;

    hdmi_i2c_init_seq #(
        .ADDRESSING       (7),
        .DEVICE_ADDRESS   (7'h39),
        .SYSCLK_FREQ      (2),
        .NUM_ENTRIES      (6),
        .STARTUP_DELAY_MS (1),
        .BYTE_TIMEOUT_US  (30),
        .GAP_US           (5),
        .MAX_RETRY        (2),
        .TABLE            (c_tb_table)
    ) dut (
        .i_sysclk    (clk),
        .i_arst      (i_arst),
        .i_start     (i_start),
        .o_m_en      (o_m_en),
        .o_m_wr      (o_m_wr),
        .o_last      (o_last),
        .o_addr      (o_addr),
        .o_data      (o_data),
        .i_ack       (i_ack),
        .i_last      (i_last),
        .i_data      (i_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_err_index (o_err_index),
        .o_dbg_state (o_dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=[%0d..%0d]", name, act, lo, hi);
        end
    endtask

    // ---------------- I2C master model: acks a byte 20 cycles after it is offered
    int unsigned att20        = 0;
    int unsigned refuse_until = 0;
    logic [8:0]  ack_log[$];
    int          rise_t[$];
    logic [7:0]  rise_d[$];
    int          stop_q[$];

    initial begin
        int   en_cnt;
        int   stop_cnt;
        logic prev_en;
        logic refusing;
        en_cnt   = 0;
        stop_cnt = 0;
        prev_en  = 1'b0;
        refusing = 1'b0;
        i_ack    = 1'b0;
        i_last   = 1'b0;
        forever begin
            @(negedge clk);
            i_ack  = 1'b0;
            i_last = 1'b0;
            if (o_m_en && !prev_en) begin
                rise_t.push_back(cyc);
                rise_d.push_back(o_data);
                refusing = 1'b0;
                if (o_data == 8'h20) begin
                    att20++;
                    refusing = (att20 <= refuse_until);
                end
            end
            prev_en = o_m_en;
            if (stop_cnt > 0) begin
                stop_cnt--;
                if (stop_cnt == 0) begin
                    i_last = 1'b1;
                    stop_q.push_back(cyc);
                end
            end else if (o_m_en) begin
                en_cnt++;
                if (en_cnt == 20 && !refusing) begin
                    i_ack  = 1'b1;
                    en_cnt = 0;
                    ack_log.push_back({o_last, o_data});
                    if (o_last) stop_cnt = 20;
                end
            end else begin
                en_cnt = 0;
            end
        end
    end

    // ---------------- scenarios: how many entry-1 attempts the slave refuses
    typedef struct {
        int unsigned nack;
        logic        exp_done;
        logic        exp_err;
        logic [7:0]  exp_idx;
        int          exp_att;
        int          exp_nbytes;
    } vec_t;

    vec_t       vecs[3];
    logic [7:0] c_bytes[8];

    initial begin
        int base_log, base_rise, base_stop, t0, n;
        int unsigned att_base;
        int others;

        vecs[0] = '{nack: 0,    exp_done: 1'b1, exp_err: 1'b0, exp_idx: 8'd0, exp_att: 1, exp_nbytes: 8};
        vecs[1] = '{nack: 1000, exp_done: 1'b0, exp_err: 1'b1, exp_idx: 8'd1, exp_att: 3, exp_nbytes: 2};
        vecs[2] = '{nack: 1,    exp_done: 1'b1, exp_err: 1'b0, exp_idx: 8'd0, exp_att: 2, exp_nbytes: 8};
        c_bytes = '{8'h10, 8'h55, 8'h20, 8'hAA, 8'h30, 8'h01, 8'h40, 8'h02};

        i_arst  = 1'b1;
        i_start = 1'b0;
        i_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_m_en",      32'(o_m_en),      32'h0);
        check("rst_last",      32'(o_last),      32'h0);
        check("rst_data",      32'(o_data),      32'h0);
        check("rst_busy",      32'(o_busy),      32'h1);
        check("rst_done",      32'(o_done),      32'h0);
        check("rst_error",     32'(o_error),     32'h0);
        check("rst_err_index", 32'(o_err_index), 32'h0);
        check("rst_state",     32'(o_dbg_state), 32'h0);
        check("addr_const",    32'(o_addr),      32'h39);
        check("wr_const",      32'(o_m_wr),      32'h1);
        i_arst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            base_log     = ack_log.size();
            base_rise    = rise_t.size();
            base_stop    = stop_q.size();
            att_base     = att20;
            refuse_until = att20 + vecs[s].nack;
            i_start = 1'b1;
            t0      = cyc;
            @(negedge clk);
            i_start = 1'b0;
            n = 0;
            while (!(o_done || o_error) && n < 20000) begin
                @(negedge clk);
                n++;
            end
            check_range($sformatf("s%0d_finish_bound", s), n, 0, 19999);
            check($sformatf("s%0d_done", s),  32'(o_done),  32'(vecs[s].exp_done));
            check($sformatf("s%0d_error", s), 32'(o_error), 32'(vecs[s].exp_err));
            check($sformatf("s%0d_busy", s),  32'(o_busy),  32'h0);
            if (vecs[s].exp_err)
                check($sformatf("s%0d_err_index", s), 32'(o_err_index), 32'(vecs[s].exp_idx));
            check($sformatf("s%0d_attempts", s), att20 - att_base, 32'(vecs[s].exp_att));
            check($sformatf("s%0d_nbytes", s), 32'(ack_log.size() - base_log), 32'(vecs[s].exp_nbytes));
            for (int k = 0; k < vecs[s].exp_nbytes; k++) begin
                if (base_log + k < ack_log.size()) begin
                    check($sformatf("s%0d_byte%0d", s, k), 32'(ack_log[base_log+k][7:0]), 32'(c_bytes[k]));
                    check($sformatf("s%0d_last%0d", s, k), 32'(ack_log[base_log+k][8]), 32'(k % 2));
                end
            end
            if (rise_t.size() > base_rise) begin
                check($sformatf("s%0d_first_reg", s), 32'(rise_d[base_rise]), 32'h10);
                check_range($sformatf("s%0d_startup_lat", s), rise_t[base_rise] - t0, 2000, 2100);
            end else begin
                check($sformatf("s%0d_any_rise", s), 32'h0, 32'h1);
            end
            others = 0;
            for (int k = base_rise; k < rise_t.size(); k++)
                if (rise_d[k] != 8'h10 && rise_d[k] != 8'h20) others++;
            check($sformatf("s%0d_later_entries", s), 32'(others), vecs[s].exp_err ? 32'h0 : 32'h2);
            if (s == 0) begin
                if (stop_q.size() > base_stop + 1 && rise_t.size() > base_rise + 2)
                    check_range("delay_gap", rise_t[base_rise+2] - stop_q[base_stop+1], 4000, 4200);
                else
                    check("delay_gap_seen", 32'h0, 32'h1);
            end
            if (vecs[s].exp_err) begin
                repeat (100) @(negedge clk);
                check("err_hold_error", 32'(o_error), 32'h1);
                check("err_hold_m_en",  32'(o_m_en),  32'h0);
            end
        end

        // i_start during the value byte of entry 3 (30:01)
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        while (!(o_m_en && o_last && o_data == 8'h01) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_range("mid_wrval_bound", n, 0, 19999);
        base_rise = rise_t.size();
        i_start = 1'b1;
        t0      = cyc;
        @(negedge clk);
        i_start = 1'b0;
        check("restart_m_en",  32'(o_m_en),      32'h0);
        check("restart_done",  32'(o_done),      32'h0);
        check("restart_busy",  32'(o_busy),      32'h1);
        check("restart_state", 32'(o_dbg_state), 32'(c_st_startup));
        n = 0;
        while (rise_t.size() == base_rise && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rise_t.size() > base_rise) begin
            check("restart_first_reg", 32'(rise_d[base_rise]), 32'h10);
            check_range("restart_lat", rise_t[base_rise] - t0, 2000, 2100);
        end else begin
            check("restart_rise_seen", 32'h0, 32'h1);
        end

        // one-cycle reset in the middle of the 2 ms delay entry
        n = 0;
        while (o_dbg_state != c_st_delay && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_range("delay_reach_bound", n, 0, 19999);
        repeat (50) @(negedge clk);
        i_arst = 1'b1;
        @(negedge clk);
        i_arst = 1'b0;
        check("mid_rst_m_en",      32'(o_m_en),      32'h0);
        check("mid_rst_last",      32'(o_last),      32'h0);
        check("mid_rst_data",      32'(o_data),      32'h0);
        check("mid_rst_busy",      32'(o_busy),      32'h1);
        check("mid_rst_done",      32'(o_done),      32'h0);
        check("mid_rst_error",     32'(o_error),     32'h0);
        check("mid_rst_err_index", 32'(o_err_index), 32'h0);
        check("mid_rst_state",     32'(o_dbg_state), 32'(c_st_startup));
        base_rise = rise_t.size();
        t0 = cyc;
        n  = 0;
        while (rise_t.size() == base_rise && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rise_t.size() > base_rise) begin
            check("post_rst_first_reg", 32'(rise_d[base_rise]), 32'h10);
            check_range("post_rst_lat", rise_t[base_rise] - t0, 1995, 2100);
        end else begin
            check("post_rst_rise_seen", 32'h0, 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hdmi_i2c_init_seq.md
Name: hdmi_i2c_init_seq

Overview:
- Power-up/re-init register sequencer for the HDMI transmitter. Walks a constant table of {register, value} pairs and issues one 2-byte I2C write per entry through the byte-level I2C master command interface (en/wr/last/addr/data in, ack/last/data out).
- Supports inline millisecond delays, per-byte timeout with bounded retry, and busy/done/error status for the display pipeline's reset and enable logic.

Parameters:
- DEVICE_ADDRESS, 7'h39, slave address of the HDMI transmitter.
- ADDRESSING, 7, address width; must match the I2C master.
- SYSCLK_FREQ, 100, i_sysclk frequency in MHz; used for microsecond and millisecond tick generation.
- NUM_ENTRIES, 32, number of table entries (1..256).
- STARTUP_DELAY_MS, 10, wait after reset or i_start before the first transaction.
- BYTE_TIMEOUT_US, 500, maximum wait for i_ack or i_last per byte or stop.
- GAP_US, 5, idle time between transactions and before a retry.
- MAX_RETRY, 3, retries per entry before error (0..15).

Ports:
- i_sysclk  in  1  system clock.
- i_arst  in  1  reset; synchronous, active-high.
- i_start  in  1  one-cycle pulse; restarts the sequence from entry 0.
- o_m_en  out  1  byte command valid to the I2C master.
- o_m_wr  out  1  write direction; always 1.
- o_last  out  1  current byte is the final byte of the transaction.
- o_addr  out  ADDRESSING  slave address; constant DEVICE_ADDRESS.
- o_data  out  8  byte to transmit.
- i_ack  in  1  one-cycle pulse: byte sent and slave ACKed.
- i_last  in  1  one-cycle pulse: STOP completed.
- i_data  in  8  read data; unused, ignored.
- o_busy  out  1  sequence in progress.
- o_done  out  1  all entries written; level, held until restart.
- o_error  out  1  retries exhausted; level, held until restart.
- o_err_index  out  8  entry index that failed.
- o_dbg_state  out  4  current FSM state encoding.

Behaviour:
- Reset: o_m_en=0, o_last=0, o_data=0, o_busy=1, o_done=0, o_error=0, o_err_index=0, index=0, retry=0; state=STARTUP.
- o_addr=DEVICE_ADDRESS and o_m_wr=1 at all times.
- Tick generator: 1 µs strobe from a counter of SYSCLK_FREQ cycles; 1 ms strobe from 1000 µs strobes. Counters clear on every state entry.
- STARTUP: wait STARTUP_DELAY_MS, then go to FETCH.
- FETCH: one cycle. Read table[index] into {reg, val}.
  - index==NUM_ENTRIES goes to DONE (o_busy=0, o_done=1).
  - reg==8'hFF is a delay entry: go to DELAY for val ms (val=0 means zero delay), then index++ and FETCH.
  - Otherwise go to WR_REG.
- WR_REG: o_m_en=1, o_data=reg, o_last=0, held stable. On i_ack go to WR_VAL in the next cycle.
- WR_VAL: o_m_en=1, o_data=val, o_last=1. On i_ack drop o_m_en and go to WAIT_STOP.
- WAIT_STOP: on i_last: index++, retry=0, go to GAP, then FETCH.
- Timeout: in WR_REG, WR_VAL or WAIT_STOP, if BYTE_TIMEOUT_US elapses with no pulse:
  - Drop o_m_en and o_last.
  - If retry<MAX_RETRY: retry++, GAP, then WR_REG with the same entry.
  - Else: ERROR (o_error=1, o_err_index=index, o_busy=0).
- i_ack in a state that does not expect it is ignored. i_ack and timeout in the same cycle: i_ack wins.
- i_start in any state: on the next cycle, clear done/error/retry/index, o_m_en=0, go to STARTUP.
  - If i_start arrives mid-transaction, the master sees o_m_en fall. It is responsible for issuing STOP; the sequencer restarts regardless.
- i_arst has priority over i_start.
- Table is combinational/ROM, NUM_ENTRIES x 16 bits, index width 8; index never wraps.

Decomposition:
- Shared package: state encodings (STARTUP, FETCH, WR_REG, WR_VAL, WAIT_STOP, GAP, DELAY, DONE, ERROR), DELAY_MARKER=8'hFF, entry layout {reg[15:8], val[7:0]}.
- Sub-module hdmi_i2c_init_table: index in, 16-bit entry out. It holds the transmitter-specific register list, so the table can change without touching the FSM.

Test Plan:
- Normal run, 3-entry table {10:55, 20:AA, 30:01}, master model acks every byte in 20 cycles -> three transactions with byte pairs 10/55, 20/AA, 30/01; o_last high only on the value byte; o_done=1 after the third i_last; o_busy=0.
- Delay entry {FF:02} between two writes, SYSCLK_FREQ=10 -> second transaction's o_m_en rises no earlier than 20000 cycles after the first i_last.
- Slave never acks entry 1, MAX_RETRY=2 -> entry 1 WR_REG attempted 3 times with o_data=20; o_error=1, o_err_index=1; entry 2 never issued.
- Entry 1 acks only on its 2nd attempt -> a single retry, sequence completes, o_done=1, o_error=0.
- i_start pulsed while in WR_VAL of entry 2 -> o_m_en=0 next cycle, o_done=0, startup delay, first byte out is entry 0 reg.
- i_arst asserted for 1 cycle mid-DELAY -> all outputs at reset values on the next edge; sequence restarts from STARTUP.
